// File: rtl/nvme_cdc_arb.sv
// Round-robin arbiter sharing one toggle-handshake CDC channel, with the ack resynchroniser nvme_cdc.
// Optional build macro: NVME_CDC_ARB_TIMEOUT_EN adds the sticky timeout_err port and WAIT-cycle counter.

// Purpose: plain flop-chain synchroniser for a single slow toggle line.
// Latency: STAGES clk edges from d to q.
// Backpressure: none; d must hold each level for at least STAGES cycles.
module nvme_cdc #(
    parameter int STAGES = 3
) (
    input  logic clk,
    input  logic d,
    output logic q
);

    // No reset here: the chain powers up to 0 and flushes while the source is held in reset.
    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        sync_q <= {sync_q[STAGES-2:0], d};
    end

    assign q = sync_q[STAGES-1];

endmodule

// Purpose: round-robin pick among NREQ requesters, hold the winner's payload, toggle xfer_req.
// Latency: xfer_req toggles 1 clk after accept; busy falls STAGES+1 clk after the ack edge.
// Backpressure: req_ready is zero whenever busy=1; one crossing outstanding at a time.
module nvme_cdc_arb #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 32,
    parameter int STAGES  = 3,
    parameter int TIMEOUT = 1024,
    localparam int SW     = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic                    xfer_req,
    output logic [WIDTH-1:0]        xfer_data,
    output logic [SW-1:0]           xfer_src,
    input  logic                    xfer_ack,
    output logic                    busy
`ifdef NVME_CDC_ARB_TIMEOUT_EN
    ,
    output logic                    timeout_err
`endif
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    typedef struct packed {
        logic [SW-1:0]    src;
        logic [WIDTH-1:0] dat;
    } hold_t;

    state_t            state, state_nxt;
    hold_t             hold_q;
    logic [SW-1:0]     last_grant;
    logic [SW-1:0]     winner;
    logic              found;
    logic              accept;
    logic              ack_sync;
    logic [WIDTH-1:0]  win_dat;

    nvme_cdc #(
        .STAGES(STAGES)
    ) u_ack_sync (
        .clk(clk),
        .d  (xfer_ack),
        .q  (ack_sync)
    );

    function automatic logic [SW-1:0] rr_idx(input logic [SW-1:0] base, input int k);
        int t;
        t = (int'(base) + k) % NREQ;
        return SW'(t);
    endfunction

    // Search upward from the slot after the previous winner, wrapping.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && req_valid[rr_idx(last_grant, k)]) begin
                found  = 1'b1;
                winner = rr_idx(last_grant, k);
            end
        end
    end

    assign win_dat = req_data[winner*WIDTH +: WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (found) begin
                    req_ready[winner] = 1'b1;
                    accept            = 1'b1;
                    state_nxt         = S_WAIT;
                end
            end
            S_WAIT: begin
                // Any ack toggle seen while idle is harmless: only equality with xfer_req matters here.
                if (ack_sync == xfer_req) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q     <= '0;
            xfer_req   <= 1'b0;
            last_grant <= SW'(NREQ - 1);
        end else if (accept) begin
            hold_q     <= '{src: winner, dat: win_dat};
            xfer_req   <= ~xfer_req;
            last_grant <= winner;
        end
    end

    assign xfer_data = hold_q.dat;
    assign xfer_src  = hold_q.src;
    assign busy      = (state == S_WAIT);

`ifdef NVME_CDC_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] to_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else if (accept) begin
            to_cnt <= '0;
        end else if (state == S_WAIT && to_cnt != CW'(TIMEOUT)) begin
            to_cnt <= to_cnt + 1'b1;
            if (to_cnt == CW'(TIMEOUT - 1)) begin
                timeout_err <= 1'b1;
            end
        end
    end
`endif

endmodule
